request_encoder: RTL and testbench
==================================

Name: request_encoder

Overview:
- Sequential encoder: the inverse of the team's 2-to-4 address decoder.
- Captures one-hot or multi-hot request lines into a sticky pending register and emits one binary address per request.
- Each address is presented under a valid/ready handshake.
- Default WIDTH=4 / ADDR_W=2 pairs directly with the decoder: address[1:0] drives address1/address0 and reproduces the original one-hot line.

Parameters:
- WIDTH, 4, number of request lines.
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= WIDTH.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req  input  WIDTH  request lines; bit i high = request for address i; sampled every cycle.
- enable  input  1  gates capture of req; low = req ignored, draining continues.
- address  output  ADDR_W  encoded index of the presented request.
- out_valid  output  1  address is valid.
- out_ready  input  1  consumer accepts address when out_valid && out_ready.
- pending  output  WIDTH  requests captured but not yet presented.
- merged  output  1  one-cycle pulse: a captured req bit was already pending.

Behaviour:
- Reset (rst_n low at edge): pending=0, address=0, out_valid=0, merged=0, FSM=IDLE. Holds while rst_n is low. Any in-flight address is discarded, not delivered.
- Capture: cap = req & {WIDTH{enable}}.
  - pending_next = (pending & ~clr) | cap, where clr is the one-hot bit selected this cycle (0 if none).
  - Set wins over clear: a req on the bit being selected in the same cycle stays pending and is presented again later.
- merged_next = |(cap & pending & ~clr); registered, so it pulses the cycle after the capture.
- Selection (fixed priority, default): lowest set index of the registered pending.
- FSM, two states:
  - IDLE: out_valid=0. If pending != 0: load address=sel, clr=onehot(sel), go PRESENT. Else stay.
  - PRESENT: out_valid=1; address and out_valid held stable until handshake.
    - On out_valid && out_ready: if (pending & ~onehot(address_old)) has bits, no bubble — same edge loads the next sel, clears its bit, stays PRESENT. Else go IDLE, out_valid drops next cycle.
    - Without handshake: no change. out_ready is ignored when out_valid=0.
- Latency: req high at edge t -> pending bit set after t -> out_valid and address valid after edge t+1, i.e. 2 cycles from idle.
- Throughput: one address per cycle while out_ready=1 and pending is non-empty.
- Boundaries:
  - All WIDTH bits pending: presented in ascending order, back-to-back.
  - Unused codes (2**ADDR_W > WIDTH) are never produced.
  - enable low with pending != 0: drains normally.
  - Repeated req pulses on a pending bit coalesce into one presentation plus merged.

Optional Feature:
- Macro ENC_ROUND_ROBIN_EN.
- Defined: selection starts at (last_granted+1) mod WIDTH and wraps. last_granted updates on each load into PRESENT and resets to WIDTH-1, so the first search starts at 0.
- Undefined: fixed lowest-index priority; no last_granted register.
- Latency, handshake and merged behaviour are identical in both builds.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, req=0 -> address=0, out_valid=0, pending=0, merged=0 throughout.
- Single request: req=4'b0100 for 1 cycle, out_ready=1 -> out_valid=1 with address=2 two edges later for exactly one cycle, pending back to 0.
- Multi-hot burst with backpressure: req=4'b1011 one cycle, out_ready=0 for 3 cycles then 1.
  - address=0 held stable while stalled.
  - Then 0,1,3 on consecutive cycles with no bubble (round-robin build: same order from reset).
- Merge and set-wins:
  - req=4'b0001 twice on consecutive cycles with out_ready=0 -> merged pulses once, single presentation of address 0.
  - Re-assert req[0] on the accepting edge -> address 0 presented a second time.
- Enable gating and mid-operation reset:
  - enable=0 with req=4'b1111 -> nothing captured.
  - Then rst_n=0 while out_valid=1, address=1 -> next edge: out_valid=0, pending=0.
- Round-robin (ENC_ROUND_ROBIN_EN): hold req=4'b1111 continuously, out_ready=1 -> address sequence 0,1,2,3,0,1… Fixed build under the same stimulus: 0 repeated.

Source files
------------

// File: rtl/request_encoder.sv
// request_encoder: sticky request capture with one address per valid/ready beat.
// Define ENC_ROUND_ROBIN_EN for rotating priority; default is lowest-index first.
module request_encoder #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  req,
    input  logic              enable,
    output logic [ADDR_W-1:0] address,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  pending,
    output logic              merged
);

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PRESENT = 1'b1;

    logic              state_q,   state_d;
    logic [WIDTH-1:0]  pending_q, pending_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              merged_q,  merged_d;

    logic [WIDTH-1:0]  cap;
    logic [WIDTH-1:0]  clr;
    logic [WIDTH-1:0]  addr_oh;
    logic [WIDTH-1:0]  sel_oh;
    logic [ADDR_W-1:0] sel;
    logic              hs;
    logic              more;
    logic              load;

    assign cap = req & {WIDTH{enable}};
    assign hs  = (state_q == ST_PRESENT) && out_ready;

    always_comb begin
        addr_oh = '0;
        sel_oh  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            addr_oh[i] = (ADDR_W'(i) == addr_q);
            sel_oh[i]  = (ADDR_W'(i) == sel);
        end
    end

`ifdef ENC_ROUND_ROBIN_EN
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] start;
    logic [ADDR_W-1:0] sel_lo;
    logic [ADDR_W-1:0] sel_hi;
    logic              hi_found;

    assign start = (last_q == ADDR_W'(WIDTH - 1)) ? '0 : last_q + 1'b1;

    // Lowest hit at or above start, else wrap to the lowest hit overall.
    always_comb begin
        sel_lo   = '0;
        sel_hi   = '0;
        hi_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_lo = ADDR_W'(i);
                if (ADDR_W'(i) >= start) begin
                    sel_hi   = ADDR_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        sel = hi_found ? sel_hi : sel_lo;
    end

    assign last_d = load ? sel : last_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= ADDR_W'(WIDTH - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel = ADDR_W'(i);
            end
        end
    end
`endif

    // Back-to-back reload only if something other than the retiring index waits.
    assign more = |(pending_q & ~addr_oh);
    assign load = ((state_q == ST_IDLE) && (|pending_q)) || (hs && more);
    assign clr  = load ? sel_oh : '0;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pending_d = (pending_q & ~clr) | cap;
        merged_d  = |(cap & pending_q & ~clr);
        if (load) begin
            state_d = ST_PRESENT;
            addr_d  = sel;
        end else if (hs) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            addr_q    <= '0;
            merged_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            merged_q  <= merged_d;
        end
    end

    assign address   = addr_q;
    assign out_valid = (state_q == ST_PRESENT);
    assign pending   = pending_q;
    assign merged    = merged_q;

endmodule

// File: tb/tb_request_encoder.sv
// Directed bench for request_encoder; expectations are hand-derived per step.
// Round-robin expectations apply when ENC_ROUND_ROBIN_EN is defined.
module tb_request_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       enable;
    logic [1:0] address;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] pending;
    logic       merged;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    request_encoder #(.WIDTH(4), .ADDR_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .enable    (enable),
        .address   (address),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .merged    (merged)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [1:0] exp_a;
        rst_n     = 1'b0;
        req       = 4'b0000;
        enable    = 1'b1;
        out_ready = 1'b0;

        // Reset then idle
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_addr", 32'(address), 32'd0);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_pend", 32'(pending), 32'd0);
            chk("rst_merged", 32'(merged), 32'd0);
        end
        rst_n = 1'b1;
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_pend", 32'(pending), 32'd0);

        // Single request, two-edge latency
        req       = 4'b0100;
        out_ready = 1'b1;
        step();
        chk("single_cap_valid", 32'(out_valid), 32'd0);
        chk("single_cap_pend", 32'(pending), 32'h4);
        req = 4'b0000;
        step();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_addr", 32'(address), 32'd2);
        chk("single_pend", 32'(pending), 32'd0);
        step();
        chk("single_drop", 32'(out_valid), 32'd0);

        // Multi-hot burst with backpressure
        do_reset();
        req       = 4'b1011;
        out_ready = 1'b0;
        step();
        chk("burst_cap", 32'(pending), 32'hb);
        req = 4'b0000;
        step();
        chk("burst_valid0", 32'(out_valid), 32'd1);
        chk("burst_addr0", 32'(address), 32'd0);
        chk("burst_pend0", 32'(pending), 32'ha);
        for (int c = 0; c < 2; c++) begin
            step();
            chk("burst_stall_addr", 32'(address), 32'd0);
            chk("burst_stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        chk("burst_addr1", 32'(address), 32'd1);
        chk("burst_valid1", 32'(out_valid), 32'd1);
        step();
        chk("burst_addr3", 32'(address), 32'd3);
        chk("burst_valid3", 32'(out_valid), 32'd1);
        chk("burst_pend3", 32'(pending), 32'd0);
        step();
        chk("burst_end", 32'(out_valid), 32'd0);

        // Merge while stalled, then set-wins on the accepting edge
        out_ready = 1'b0;
        req       = 4'b0010;
        step();
        req = 4'b0000;
        step();
        chk("merge_hold_addr", 32'(address), 32'd1);
        req = 4'b0001;
        step();
        chk("merge_first", 32'(merged), 32'd0);
        chk("merge_pend", 32'(pending), 32'h1);
        step();
        chk("merge_pulse", 32'(merged), 32'd1);
        req = 4'b0000;
        step();
        chk("merge_clear", 32'(merged), 32'd0);
        chk("merge_still1", 32'(address), 32'd1);
        out_ready = 1'b1;
        step();
        chk("merge_pres0", 32'(address), 32'd0);
        chk("merge_pres0_v", 32'(out_valid), 32'd1);
        chk("merge_pend0", 32'(pending), 32'd0);
        req = 4'b0001;
        step();
        chk("setwin_idle", 32'(out_valid), 32'd0);
        chk("setwin_pend", 32'(pending), 32'h1);
        req = 4'b0000;
        step();
        chk("setwin_again_v", 32'(out_valid), 32'd1);
        chk("setwin_again_a", 32'(address), 32'd0);
        step();
        chk("setwin_done", 32'(out_valid), 32'd0);

        // Enable gating and mid-operation reset
        out_ready = 1'b0;
        enable    = 1'b0;
        req       = 4'b1111;
        step();
        step();
        chk("gate_pend", 32'(pending), 32'd0);
        chk("gate_valid", 32'(out_valid), 32'd0);
        enable = 1'b1;
        req    = 4'b0010;
        step();
        req = 4'b0000;
        step();
        chk("mid_valid", 32'(out_valid), 32'd1);
        chk("mid_addr", 32'(address), 32'd1);
        enable = 1'b0;
        req    = 4'b1111;
        step();
        chk("mid_gate_pend", 32'(pending), 32'd0);
        rst_n  = 1'b0;
        enable = 1'b1;
        req    = 4'b0000;
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_pend", 32'(pending), 32'd0);
        chk("mid_rst_addr", 32'(address), 32'd0);
        rst_n = 1'b1;
        step();

        // Continuous all-hot request with out_ready high
        req       = 4'b1111;
        out_ready = 1'b1;
        step();
        chk("hold_cap", 32'(pending), 32'hf);
        for (int c = 0; c < 6; c++) begin
            step();
`ifdef ENC_ROUND_ROBIN_EN
            exp_a = 2'(c % 4);
`else
            exp_a = 2'd0;
`endif
            chk("hold_addr", 32'(address), 32'(exp_a));
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
